// File: rtl/sw_debounce_if.sv
// Change-event channel of sw_debounce: a latest-wins valid/ready event carrying
// the debounced switch word, plus an overrun strobe.
interface sw_debounce_if #(
  parameter int WIDTH = 4
);
  logic             chg_valid;
  logic             chg_ready;
  logic [WIDTH-1:0] chg_data;
  logic             chg_overrun;

  modport master (output chg_valid, output chg_data, output chg_overrun, input chg_ready);
  modport slave  (input chg_valid, input chg_data, input chg_overrun, output chg_ready);
endinterface

// File: rtl/sw_debounce_bit.sv
// One switch line: synchroniser, stability counter, stable flop and rise/fall strobes.
// accept/stable_nxt are combinational so the top can register its event in step with sw_stable.
module sw_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic stable,
  output logic rise,
  output logic fall,
  output logic accept,
  output logic stable_nxt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   s;

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    accept     = (s != stable) && (cnt == CNT_MAX);
    stable_nxt = accept ? s : stable;
    cnt_nxt    = '0;
    // counting only while the sample disagrees; acceptance and agreement both return to 0
    if ((s != stable) && !accept) cnt_nxt = cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync   <= '0;
      cnt    <= '0;
      stable <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], raw};
      cnt    <= cnt_nxt;
      stable <= stable_nxt;
      rise   <= accept & s;
      fall   <= accept & ~s;
    end
  end
endmodule

// File: rtl/sw_debounce.sv
// Switch conditioning top: WIDTH debounced lines, any_on summary and a
// latest-wins change event that overwrites (and flags) an unaccepted one.
module sw_debounce #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_on,
  sw_debounce_if.master    chg
);
  logic [WIDTH-1:0] accept, stable_nxt;
  logic             chg_any, acc;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    sw_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .rst_n     (rst_n),
      .raw       (sw_raw[b]),
      .stable    (sw_stable[b]),
      .rise      (rise[b]),
      .fall      (fall[b]),
      .accept    (accept[b]),
      .stable_nxt(stable_nxt[b])
    );
  end

  assign chg_any = |accept;
  assign acc     = chg.chg_valid & chg.chg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_on          <= 1'b0;
      chg.chg_valid   <= 1'b0;
      chg.chg_data    <= '0;
      chg.chg_overrun <= 1'b0;
    end else begin
      any_on          <= |stable_nxt;
      chg.chg_overrun <= 1'b0;
      if (chg_any) begin
        chg.chg_valid   <= 1'b1;
        chg.chg_data    <= stable_nxt;
        // a consumed-this-cycle event is not lost, so it is not an overrun
        chg.chg_overrun <= chg.chg_valid & ~chg.chg_ready;
      end else if (acc) begin
        chg.chg_valid <= 1'b0;
      end
    end
  end
endmodule
